sram_responder: RTL and testbench

Cycle-based responder for the external 16-bit asynchronous-SRAM bus that the memory controller drives. It decodes the active-low chip/write/output/byte-lane strobes, stores 16-bit words, and returns read data on the shared tri-state bus after a programmable latency. It serves as the board-RAM stand-in for system simulation and as the bus-side reference for verifying the memory controller's timing.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_lane_drv.sv | 19 +
 rtl/sram_responder.sv | 159 +++++++++++++++
 tb/tb_sram_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types and constants for the async-SRAM bus responder.
// Revision : 1.0
// ============================================================================
package sram_pkg;

    localparam int c_DATA_W           = 16;
    localparam int c_LANE_W           = 8;
    localparam int c_LANES            = 2;
    localparam int c_DEFAULT_READ_LAT = 2;
    localparam int c_LAT_W            = 3;

    // All bus strobes are active-low.
    localparam logic c_ASSERTED = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_READ_DRIVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_lane_drv.sv
`default_nettype none
// ============================================================================
// Module   : sram_lane_drv
// Brief    : Tri-state driver for one byte lane of the shared data bus.
// Revision : 1.0
// ============================================================================
module sram_lane_drv
    import sram_pkg::*;
(
    input  logic                drive_en,
    input  logic                lane_mask,
    input  logic [c_LANE_W-1:0] word,
    inout  wire  [c_LANE_W-1:0] lane
);

    assign lane = (drive_en && (lane_mask == c_ASSERTED)) ? word : {c_LANE_W{1'bz}};

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Brief    : Cycle-based 16-bit async-SRAM bus responder with read latency.
// Revision : 1.0
// ============================================================================
module sram_responder
    import sram_pkg::*;
#(
    parameter int    ADDR_W    = 18,
    parameter int    MEM_WORDS = 4096,
    parameter int    READ_LAT  = c_DEFAULT_READ_LAT,
    parameter string INIT_FILE = ""
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [c_DATA_W-1:0] data,
    input  logic              wre,
    input  logic              oute,
    input  logic              hb_mask,
    input  logic              lb_mask,
    input  logic              chip_en,
    output logic              contention,
    output logic              oob_err,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int c_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [c_DATA_W-1:0] r_mem [0:MEM_WORDS-1];

    state_t              r_state, w_nxt_state;
    logic [c_LAT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [ADDR_W-1:0]   r_rd_addr, w_nxt_rd_addr;
    logic                r_drive_en, w_nxt_drive;

    logic w_read_req, w_write_req, w_addr_ok, w_rd_ok;
    logic w_do_write, w_start_read, w_rd_done, w_contention, w_oob;
    logic [c_DATA_W-1:0] w_rd_word;
    logic [c_LANES-1:0]  w_lane_mask;

    assign w_write_req = (chip_en == c_ASSERTED) && (wre == c_ASSERTED);
    assign w_read_req  = (chip_en == c_ASSERTED) && (wre != c_ASSERTED) && (oute == c_ASSERTED);
    assign w_addr_ok   = 32'(addr) < 32'(MEM_WORDS);
    assign w_rd_ok     = 32'(r_rd_addr) < 32'(MEM_WORDS);
    assign w_rd_word   = w_rd_ok ? r_mem[r_rd_addr[c_IDX_W-1:0]] : '0;
    assign w_lane_mask = {hb_mask, lb_mask};

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_rd_addr = r_rd_addr;
        w_nxt_drive   = r_drive_en;
        w_do_write    = 1'b0;
        w_start_read  = 1'b0;
        w_rd_done     = 1'b0;
        w_contention  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_write_req)
                    w_do_write = 1'b1;
                else if (w_read_req)
                    w_start_read = 1'b1;
            end
            ST_READ_WAIT: begin
                // Any strobe change aborts; a write strobe is honoured at once.
                if (!w_read_req) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_drive = 1'b0;
                    w_do_write  = w_write_req;
                end else if (r_cnt == '0) begin
                    w_nxt_state = ST_READ_DRIVE;
                    w_nxt_drive = 1'b1;
                    w_rd_done   = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - c_LAT_W'(1);
                end
            end
            ST_READ_DRIVE: begin
                if (w_write_req) begin
                    w_contention = 1'b1;
                    w_nxt_state  = ST_IDLE;
                    w_nxt_drive  = 1'b0;
                end else if (!w_read_req) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_drive = 1'b0;
                end else if (addr != r_rd_addr) begin
                    w_start_read = 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_drive = 1'b0;
            end
        endcase

        if (w_start_read) begin
            w_nxt_rd_addr = addr;
            if (READ_LAT == 1) begin
                w_nxt_state = ST_READ_DRIVE;
                w_nxt_drive = 1'b1;
                w_rd_done   = 1'b1;
            end else begin
                w_nxt_state = ST_READ_WAIT;
                w_nxt_cnt   = c_LAT_W'(READ_LAT - 1);
                w_nxt_drive = 1'b0;
            end
        end

        w_oob = (w_do_write || w_start_read) && !w_addr_ok;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_drive_en <= 1'b0;
            contention <= 1'b0;
            oob_err    <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_rd_addr  <= w_nxt_rd_addr;
            r_drive_en <= w_nxt_drive;
            contention <= w_contention;
            oob_err    <= w_oob;
            if (w_rd_done)
                rd_count <= rd_count + 32'd1;
            if (w_do_write)
                wr_count <= wr_count + 32'd1;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (w_do_write && w_addr_ok) begin
            if (lb_mask == c_ASSERTED)
                r_mem[addr[c_IDX_W-1:0]][7:0]  <= data[7:0];
            if (hb_mask == c_ASSERTED)
                r_mem[addr[c_IDX_W-1:0]][15:8] <= data[15:8];
        end
    end

    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        sram_lane_drv u_lane_drv (
            .drive_en  (r_drive_en),
            .lane_mask (w_lane_mask[i]),
            .word      (w_rd_word[c_LANE_W*i +: c_LANE_W]),
            .lane      (data[c_LANE_W*i +: c_LANE_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Brief    : Directed, table-driven bench; released bus lanes read as pulled-up 1s.
// Revision : 1.0
// ============================================================================
module tb_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] addr;
    logic        wre, oute, hb_mask, lb_mask, chip_en;
    logic        tb_oe;
    logic [15:0] tb_wdata;
    wire  [15:0] data;
    wire         contention, oob_err;
    wire  [31:0] rd_count, wr_count;

    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    assign data = tb_oe ? tb_wdata : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (data[i]);
    end

    sram_responder #(
        .ADDR_W    (18),
        .MEM_WORDS (4096),
        .READ_LAT  (2),
        .INIT_FILE ("")
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .wre        (wre),
        .oute       (oute),
        .hb_mask    (hb_mask),
        .lb_mask    (lb_mask),
        .chip_en    (chip_en),
        .contention (contention),
        .oob_err    (oob_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [17:0] addr;
        logic        do_wr;
        logic [15:0] wdata;
        logic        whb, wlb;
        logic        rhb, rlb;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        @(negedge clock);
        chip_en = 1'b1; wre = 1'b1; oute = 1'b1;
        hb_mask = 1'b0; lb_mask = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic hb, input logic lb, input logic exp_oob);
        @(negedge clock);
        addr = a; chip_en = 1'b0; wre = 1'b0; oute = 1'b1;
        hb_mask = hb; lb_mask = lb; tb_oe = 1'b1; tb_wdata = d;
        tick();
        exp_wr++;
        check("wr_count", wr_count, 32'(exp_wr));
        check("wr_oob", {31'd0, oob_err}, {31'd0, exp_oob});
        bus_idle();
    endtask

    // Leaves the strobes asserted with the DUT in READ_DRIVE.
    task automatic read_check(input logic [17:0] a, input logic hb, input logic lb,
                              input logic [15:0] exp, input logic exp_oob);
        @(negedge clock);
        addr = a; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
        hb_mask = hb; lb_mask = lb; tb_oe = 1'b0;
        tick();
        check("rd_oob", {31'd0, oob_err}, {31'd0, exp_oob});
        check("rd_lat0", {16'd0, data}, 32'h0000FFFF);
        tick();
        check("rd_lat1", {16'd0, data}, 32'h0000FFFF);
        tick();
        exp_rd++;
        check("rd_data", {16'd0, data}, {16'd0, exp});
        check("rd_count", rd_count, 32'(exp_rd));
    endtask

    initial begin
        vecs[0] = '{18'h00010, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        vecs[1] = '{18'h00005, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
        vecs[2] = '{18'h00005, 1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h12CD};
        vecs[3] = '{18'h00005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h12FF};
        vecs[4] = '{18'h00006, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFF5A};
        vecs[5] = '{18'h00000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111};
        vecs[6] = '{18'h00FFF, 1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F};
        vecs[7] = '{18'h00006, 1'b1, 16'hC3C3, 1'b0, 1'b1, 1'b0, 1'b0, 16'hC35A};

        reset = 1'b0; addr = '0; tb_oe = 1'b0; tb_wdata = '0;
        chip_en = 1'b1; wre = 1'b1; oute = 1'b1; hb_mask = 1'b0; lb_mask = 1'b0;
        tick();
        tick();
        check("rst_contention", {31'd0, contention}, 32'd0);
        check("rst_oob", {31'd0, oob_err}, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_data_z", {16'd0, data}, 32'h0000FFFF);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].whb, vecs[i].wlb, 1'b0);
            read_check(vecs[i].addr, vecs[i].rhb, vecs[i].rlb, vecs[i].exp, 1'b0);
            bus_idle();
        end

        // Address change while driving: two released cycles, then new word.
        read_check(18'h00005, 1'b0, 1'b0, 16'h12CD, 1'b0);
        @(negedge clock);
        addr = 18'h00006;
        tick();
        check("achg_z0", {16'd0, data}, 32'h0000FFFF);
        tick();
        check("achg_z1", {16'd0, data}, 32'h0000FFFF);
        tick();
        exp_rd++;
        check("achg_data", {16'd0, data}, 32'h0000C35A);
        check("achg_rd_count", rd_count, 32'(exp_rd));
        bus_idle();

        // Contention: write strobe while driving is dropped, bus released.
        read_check(18'h00006, 1'b0, 1'b0, 16'hC35A, 1'b0);
        @(negedge clock);
        wre = 1'b0;
        tick();
        check("cont_pulse", {31'd0, contention}, 32'd1);
        check("cont_release", {16'd0, data}, 32'h0000FFFF);
        check("cont_no_wr", wr_count, 32'(exp_wr));
        bus_idle();
        tick();
        check("cont_one_cycle", {31'd0, contention}, 32'd0);
        read_check(18'h00006, 1'b0, 1'b0, 16'hC35A, 1'b0);
        @(negedge clock);
        wre = 1'b0; tb_oe = 1'b1; tb_wdata = 16'h5555;
        tick();
        check("cont2_pulse", {31'd0, contention}, 32'd1);
        tick();
        exp_wr++;
        check("cont2_retry_wr", wr_count, 32'(exp_wr));
        check("cont2_clear", {31'd0, contention}, 32'd0);
        bus_idle();
        read_check(18'h00006, 1'b0, 1'b0, 16'h5555, 1'b0);
        bus_idle();

        // Out-of-range accesses.
        do_write(18'd4096, 16'h7777, 1'b0, 1'b0, 1'b1);
        tick();
        check("oob_one_cycle", {31'd0, oob_err}, 32'd0);
        read_check(18'd4096, 1'b0, 1'b0, 16'h0000, 1'b1);
        bus_idle();
        read_check(18'h00000, 1'b0, 1'b0, 16'h1111, 1'b0);
        bus_idle();

        // Read aborted in READ_WAIT by OE release.
        @(negedge clock);
        addr = 18'h00010; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
        tick();
        @(negedge clock);
        oute = 1'b1;
        tick();
        tick();
        check("abort_oe_z", {16'd0, data}, 32'h0000FFFF);
        check("abort_oe_rd", rd_count, 32'(exp_rd));
        bus_idle();

        // Read aborted in READ_WAIT by a write, which takes effect.
        @(negedge clock);
        addr = 18'h00020; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
        tick();
        @(negedge clock);
        wre = 1'b0; tb_oe = 1'b1; tb_wdata = 16'h2222;
        tick();
        exp_wr++;
        check("abort_wr_count", wr_count, 32'(exp_wr));
        check("abort_wr_rd", rd_count, 32'(exp_rd));
        bus_idle();
        read_check(18'h00020, 1'b0, 1'b0, 16'h2222, 1'b0);
        bus_idle();

        // Asynchronous reset in READ_WAIT.
        @(negedge clock);
        addr = 18'h00010; chip_en = 1'b0; wre = 1'b1; oute = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        exp_rd = 0; exp_wr = 0;
        check("arst_wait_z", {16'd0, data}, 32'h0000FFFF);
        check("arst_wait_rd", rd_count, 32'd0);
        check("arst_wait_wr", wr_count, 32'd0);
        bus_idle();
        @(negedge clock);
        reset = 1'b1;
        read_check(18'h00010, 1'b0, 1'b0, 16'hBEEF, 1'b0);

        // Asynchronous reset in READ_DRIVE.
        #2 reset = 1'b0;
        #1;
        exp_rd = 0;
        check("arst_drv_z", {16'd0, data}, 32'h0000FFFF);
        check("arst_drv_rd", rd_count, 32'd0);
        check("arst_drv_wr", wr_count, 32'd0);
        bus_idle();
        @(negedge clock);
        reset = 1'b1;
        read_check(18'h00006, 1'b0, 1'b0, 16'h5555, 1'b0);
        bus_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
